rtc_read_sequencer: RTL and testbench



---
 rtl/rtc_read_sequencer_pkg.sv | 55 +++++
 rtl/rtc_read_sequencer_if.sv | 26 ++
 rtl/rtc_read_sequencer_shadow_bank.sv | 42 ++++
 rtl/rtc_read_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_read_sequencer_pkg.sv
// Shared definitions for the RTC read and write sequencers.
// Holds the sequencer state encoding, RTC register addresses, command bytes
// and small helpers that map a read state to its shadow-register slot.
package rtc_read_sequencer_pkg;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StArm     = 4'd1,
      StCmd     = 4'd2,
      StRdSeg   = 4'd3,
      StRdMin   = 4'd4,
      StRdHora  = 4'd5,
      StRdDia   = 4'd6,
      StRdMes   = 4'd7,
      StRdAno   = 4'd8,
      StRdTSeg  = 4'd9,
      StRdTMin  = 4'd10,
      StRdTHora = 4'd11,
      StDone    = 4'd12
   } rtc_state_e;

   // Transfer commands: F0 copies clock -> RAM (read side); F1/F2 are the
   // write-side transfers used by the write sequencer.
   localparam logic [7:0] CmdXfer      = 8'hF0;
   localparam logic [7:0] CmdXferClk   = 8'hF1;
   localparam logic [7:0] CmdXferTmr   = 8'hF2;
   localparam logic [7:0] CmdData      = 8'h00;

   // Clock registers live at 0x21..0x26, timer registers at 0x41..0x43.
   localparam logic [7:0] AddrClkBase  = 8'h21;
   localparam logic [7:0] AddrTmrBase  = 8'h41;

   localparam int unsigned NumRegs     = 9;
   localparam int unsigned NumClkRegs  = 6;

   localparam int unsigned IdxSeg   = 0;
   localparam int unsigned IdxMin   = 1;
   localparam int unsigned IdxHora  = 2;
   localparam int unsigned IdxDia   = 3;
   localparam int unsigned IdxMes   = 4;
   localparam int unsigned IdxAno   = 5;
   localparam int unsigned IdxTSeg  = 6;
   localparam int unsigned IdxTMin  = 7;
   localparam int unsigned IdxTHora = 8;

   function automatic logic is_rd_state(rtc_state_e s);
      return (s >= StRdSeg) && (s <= StRdTHora);
   endfunction

   // Shadow slot for a read state; only meaningful when is_rd_state() holds.
   function automatic logic [3:0] rd_sel(rtc_state_e s);
      return 4'(s) - 4'(StRdSeg);
   endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Bus between the RTC sequencer and the shared DIR/DAT/cambio_estado
// bus-cycle generator.
//   master : sequencer side (drives Dato_Dire, E_lect, Rd_Wr, Bus_OE)
//   slave  : generator side (drives DIR, DAT, cambio_estado, Dato_In)
interface rtc_read_sequencer_if;

   logic       DIR;
   logic       DAT;
   logic       cambio_estado;
   logic [7:0] Dato_In;
   logic [7:0] Dato_Dire;
   logic       E_lect;
   logic       Rd_Wr;
   logic       Bus_OE;

   modport master (
      input  DIR, DAT, cambio_estado, Dato_In,
      output Dato_Dire, E_lect, Rd_Wr, Bus_OE
   );

   modport slave (
      output DIR, DAT, cambio_estado, Dato_In,
      input  Dato_Dire, E_lect, Rd_Wr, Bus_OE
   );

endinterface

// File: rtl/rtc_read_sequencer_shadow_bank.sv
// rtc_shadow_bank: nine capture (shadow) registers plus their published copies.
//   clk, reset  : clock, async active-high reset (clears everything)
//   load_sel_i  : shadow slot written when cap_en_i is high (0..8)
//   cap_en_i    : load dato_in_i into the selected shadow
//   dato_in_i   : byte from the RTC bus
//   publish_i   : copy all shadows to pub_o at this edge
//   pub_o       : published bytes, slot order Seg..T_Hora
module rtc_shadow_bank
   import rtc_read_sequencer_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [3:0]                load_sel_i,
   input  logic                      cap_en_i,
   input  logic [7:0]                dato_in_i,
   input  logic                      publish_i,
   output logic [NumRegs-1:0][7:0]   pub_o
);

   logic [NumRegs-1:0][7:0] shadow_q;
   logic [NumRegs-1:0][7:0] pub_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
         pub_q    <= '0;
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            if (cap_en_i && (load_sel_i == 4'(i))) begin
               shadow_q[i] <= dato_in_i;
            end
         end
         // All nine bytes move together so readers never see a mixed time.
         if (publish_i) begin
            pub_q <= shadow_q;
         end
      end
   end

   assign pub_o = pub_q;

endmodule

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer. On Lectura_i it writes the clock->RAM transfer command,
// then reads the six clock and three timer registers through the shared bus
// generator, and publishes all nine bytes at once with a one-cycle
// Dato_Valido_o strobe.
//   clk, reset    : clock, async active-high reset
//   Lectura_i     : read request, sampled only while idle
//   bus           : generator handshake (master side)
//   Term_Lect_o   : 1 while idle / finished
//   Dato_Valido_o : one-cycle pulse when published outputs update
//   Seg_o..T_Hora_o : published register values
module rtc_read_sequencer
   import rtc_read_sequencer_pkg::*;
#(
   parameter logic [7:0] CMD_XFER      = CmdXfer,
   parameter logic [7:0] CMD_DATA      = CmdData,
   parameter logic [7:0] ADDR_CLK_BASE = AddrClkBase,
   parameter logic [7:0] ADDR_TMR_BASE = AddrTmrBase
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Lectura_i,
   rtc_read_sequencer_if.master bus,
   output logic                 Term_Lect_o,
   output logic                 Dato_Valido_o,
   output logic [7:0]           Seg_o,
   output logic [7:0]           Min_o,
   output logic [7:0]           Hora_o,
   output logic [7:0]           Dia_o,
   output logic [7:0]           Mes_o,
   output logic [7:0]           Ano_o,
   output logic [7:0]           T_Seg_o,
   output logic [7:0]           T_Min_o,
   output logic [7:0]           T_Hora_o
);

   rtc_state_e state_q, state_d;
   logic       e_lect_q, e_lect_d;
   logic       rd_wr_q, rd_wr_d;
   logic       bus_oe_q, bus_oe_d;
   logic       term_lect_q, term_lect_d;
   logic       dato_valido_q, dato_valido_d;
   logic [7:0] dato_dire_q, dato_dire_d;

   logic       cap_en;
   logic       publish;
   logic [3:0] load_sel;
   logic [7:0] state_addr;
   rtc_state_e next_bus_state;
   logic [NumRegs-1:0][7:0] pub;

   assign load_sel       = rd_sel(state_q);
   assign next_bus_state = rtc_state_e'(4'(state_q) + 4'd1);

   always_comb begin
      state_addr = CMD_XFER;
      if (is_rd_state(state_q)) begin
         if (load_sel < 4'(NumClkRegs)) begin
            state_addr = ADDR_CLK_BASE + {4'b0, load_sel};
         end else begin
            state_addr = ADDR_TMR_BASE + {4'b0, load_sel - 4'(NumClkRegs)};
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      e_lect_d      = e_lect_q;
      rd_wr_d       = rd_wr_q;
      bus_oe_d      = bus_oe_q;
      term_lect_d   = term_lect_q;
      dato_dire_d   = dato_dire_q;
      dato_valido_d = 1'b0;
      cap_en        = 1'b0;
      publish       = 1'b0;

      case (state_q)
         StIdle: begin
            e_lect_d    = 1'b0;
            term_lect_d = 1'b1;
            if (Lectura_i) begin
               state_d     = StArm;
               term_lect_d = 1'b0;
            end
         end

         StArm: begin
            e_lect_d = 1'b1;
            rd_wr_d  = 1'b0;
            state_d  = StCmd;
         end

         StCmd, StRdSeg, StRdMin, StRdHora, StRdDia, StRdMes, StRdAno,
         StRdTSeg, StRdTMin, StRdTHora: begin
            if (bus.DIR) begin
               dato_dire_d = state_addr;
               bus_oe_d    = 1'b1;
            end else if (bus.DAT) begin
               if (state_q == StCmd) begin
                  dato_dire_d = CMD_DATA;
                  bus_oe_d    = 1'b1;
               end else begin
                  bus_oe_d = 1'b0;
                  cap_en   = 1'b1;
               end
            end else if (bus.cambio_estado) begin
               // E_lect low for this one cycle separates consecutive bus cycles.
               state_d  = next_bus_state;
               e_lect_d = 1'b0;
               bus_oe_d = 1'b0;
               rd_wr_d  = is_rd_state(next_bus_state);
            end else begin
               e_lect_d = 1'b1;
            end
         end

         StDone: begin
            publish       = 1'b1;
            dato_valido_d = 1'b1;
            term_lect_d   = 1'b1;
            rd_wr_d       = 1'b0;
            state_d       = StIdle;
         end

         default: begin
            state_d     = StIdle;
            e_lect_d    = 1'b0;
            bus_oe_d    = 1'b0;
            term_lect_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         e_lect_q      <= 1'b0;
         rd_wr_q       <= 1'b0;
         bus_oe_q      <= 1'b0;
         term_lect_q   <= 1'b1;
         dato_valido_q <= 1'b0;
         dato_dire_q   <= 8'h00;
      end else begin
         state_q       <= state_d;
         e_lect_q      <= e_lect_d;
         rd_wr_q       <= rd_wr_d;
         bus_oe_q      <= bus_oe_d;
         term_lect_q   <= term_lect_d;
         dato_valido_q <= dato_valido_d;
         dato_dire_q   <= dato_dire_d;
      end
   end

   rtc_shadow_bank u_shadow_bank (
      .clk        (clk),
      .reset      (reset),
      .load_sel_i (load_sel),
      .cap_en_i   (cap_en),
      .dato_in_i  (bus.Dato_In),
      .publish_i  (publish),
      .pub_o      (pub)
   );

   assign bus.E_lect    = e_lect_q;
   assign bus.Rd_Wr     = rd_wr_q;
   assign bus.Bus_OE    = bus_oe_q;
   assign bus.Dato_Dire = dato_dire_q;

   assign Term_Lect_o   = term_lect_q;
   assign Dato_Valido_o = dato_valido_q;
   assign Seg_o         = pub[IdxSeg];
   assign Min_o         = pub[IdxMin];
   assign Hora_o        = pub[IdxHora];
   assign Dia_o         = pub[IdxDia];
   assign Mes_o         = pub[IdxMes];
   assign Ano_o         = pub[IdxAno];
   assign T_Seg_o       = pub[IdxTSeg];
   assign T_Min_o       = pub[IdxTMin];
   assign T_Hora_o      = pub[IdxTHora];

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Testbench for rtc_read_sequencer: the bench plays the bus generator and
// keeps a scoreboard of expected addresses and published bytes.
module tb_rtc_read_sequencer;

   logic clk = 1'b0;
   logic reset;
   logic Lectura;
   logic Term_Lect, Dato_Valido;
   logic [7:0] Seg, Min, Hora, Dia, Mes, Ano, T_Seg, T_Min, T_Hora;

   rtc_read_sequencer_if bus_if ();

   rtc_read_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .Lectura_i     (Lectura),
      .bus           (bus_if),
      .Term_Lect_o   (Term_Lect),
      .Dato_Valido_o (Dato_Valido),
      .Seg_o         (Seg),
      .Min_o         (Min),
      .Hora_o        (Hora),
      .Dia_o         (Dia),
      .Mes_o         (Mes),
      .Ano_o         (Ano),
      .T_Seg_o       (T_Seg),
      .T_Min_o       (T_Min),
      .T_Hora_o      (T_Hora)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int bus_cycles;

   logic [7:0] got [9];
   logic [7:0] pub_model [9];
   logic [7:0] addr_tab [10];
   logic [7:0] exp_addr_q [$];
   logic [7:0] exp_pub_q [$];

   assign got[0] = Seg;
   assign got[1] = Min;
   assign got[2] = Hora;
   assign got[3] = Dia;
   assign got[4] = Mes;
   assign got[5] = Ano;
   assign got[6] = T_Seg;
   assign got[7] = T_Min;
   assign got[8] = T_Hora;

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (Term_Lect !== 1'b1 || bus_if.E_lect !== 1'b0 || Dato_Valido !== 1'b0 ||
          bus_if.Bus_OE !== 1'b0 || bus_if.Rd_Wr !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: Term_Lect=%b E_lect=%b Valido=%b Bus_OE=%b Rd_Wr=%b want 1 0 0 0 0",
                  Term_Lect, bus_if.E_lect, Dato_Valido, bus_if.Bus_OE, bus_if.Rd_Wr);
      end
      checks++;
      if (bus_if.Dato_Dire !== 8'h00) begin
         errors++;
         $display("FAIL reset_dire: got %h want 00", bus_if.Dato_Dire);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (got[i] !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte[%0d]: got %h want 00", i, got[i]);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_read(input logic [7:0] mask);
      for (int i = 0; i < 10; i++) exp_addr_q.push_back(addr_tab[i]);
      for (int i = 1; i < 10; i++) exp_pub_q.push_back(addr_tab[i] ^ mask);
      Lectura = 1'b1;
      @(negedge clk);
      Lectura = 1'b0;
      checks++;
      if (Term_Lect !== 1'b0) begin
         errors++;
         $display("FAIL start_term_lect: got %b want 0", Term_Lect);
      end
   endtask

   // One generator bus cycle: 3 DIR, 3 DAT, 1 cambio_estado.
   task automatic bus_cycle(input int idx, input logic [7:0] mask, input int busy_idx,
                            input int rst_idx, output bit aborted);
      int n = 0;
      logic [7:0] a;
      logic rd;
      aborted = 1'b0;
      while (bus_if.E_lect !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus_if.E_lect !== 1'b1) begin
         errors++;
         $display("FAIL e_lect_timeout[%0d]: E_lect=%b want 1 within 20 cycles", idx,
                  bus_if.E_lect);
         aborted = 1'b1;
         return;
      end
      bus_cycles++;
      rd = (idx != 0);
      a  = exp_addr_q.pop_front();
      checks++;
      if (bus_if.Rd_Wr !== rd) begin
         errors++;
         $display("FAIL rd_wr[%0d]: got %b want %b", idx, bus_if.Rd_Wr, rd);
      end
      bus_if.DIR = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (idx == busy_idx && k == 0) Lectura = 1'b1;
         @(negedge clk);
         Lectura = 1'b0;
         checks++;
         if (bus_if.Dato_Dire !== a || bus_if.Bus_OE !== 1'b1) begin
            errors++;
            $display("FAIL dir_phase[%0d]: Dato_Dire=%h Bus_OE=%b want %h 1", idx,
                     bus_if.Dato_Dire, bus_if.Bus_OE, a);
         end
         checks++;
         if (Term_Lect !== 1'b0 || Dato_Valido !== 1'b0) begin
            errors++;
            $display("FAIL busy_flags[%0d]: Term_Lect=%b Valido=%b want 0 0", idx, Term_Lect,
                     Dato_Valido);
         end
         for (int j = 0; j < 9; j++) begin
            checks++;
            if (got[j] !== pub_model[j]) begin
               errors++;
               $display("FAIL hold[%0d][%0d]: got %h want %h", idx, j, got[j], pub_model[j]);
            end
         end
      end
      bus_if.DIR = 1'b0;
      bus_if.DAT = 1'b1;
      for (int k = 0; k < 3; k++) begin
         // Only the final DAT sample carries the real byte.
         bus_if.Dato_In = (k == 2) ? (a ^ mask) : 8'($urandom);
         @(negedge clk);
         if (idx == rst_idx && k == 1) begin
            reset = 1'b1;
            bus_if.DAT = 1'b0;
            @(negedge clk);
            checks++;
            if (bus_if.E_lect !== 1'b0 || Term_Lect !== 1'b1 || Dato_Valido !== 1'b0 ||
                bus_if.Bus_OE !== 1'b0) begin
               errors++;
               $display("FAIL midop_reset_ctrl: E_lect=%b Term_Lect=%b Valido=%b Bus_OE=%b want 0 1 0 0",
                        bus_if.E_lect, Term_Lect, Dato_Valido, bus_if.Bus_OE);
            end
            for (int j = 0; j < 9; j++) begin
               pub_model[j] = 8'h00;
               checks++;
               if (got[j] !== 8'h00) begin
                  errors++;
                  $display("FAIL midop_reset_byte[%0d]: got %h want 00", j, got[j]);
               end
            end
            exp_addr_q.delete();
            exp_pub_q.delete();
            reset = 1'b0;
            @(negedge clk);
            aborted = 1'b1;
            return;
         end
         checks++;
         if (rd && bus_if.Bus_OE !== 1'b0) begin
            errors++;
            $display("FAIL rd_dat_oe[%0d]: Bus_OE=%b want 0", idx, bus_if.Bus_OE);
         end else if (!rd && (bus_if.Bus_OE !== 1'b1 || bus_if.Dato_Dire !== 8'h00)) begin
            errors++;
            $display("FAIL cmd_dat[%0d]: Bus_OE=%b Dato_Dire=%h want 1 00", idx, bus_if.Bus_OE,
                     bus_if.Dato_Dire);
         end
      end
      bus_if.DAT = 1'b0;
      bus_if.cambio_estado = 1'b1;
      @(negedge clk);
      bus_if.cambio_estado = 1'b0;
      checks++;
      if (bus_if.E_lect !== 1'b0 || bus_if.Bus_OE !== 1'b0) begin
         errors++;
         $display("FAIL gap_low[%0d]: E_lect=%b Bus_OE=%b want 0 0", idx, bus_if.E_lect,
                  bus_if.Bus_OE);
      end
      if (idx < 9) begin
         @(negedge clk);
         checks++;
         if (bus_if.E_lect !== 1'b1) begin
            errors++;
            $display("FAIL gap_one_cycle[%0d]: E_lect=%b want 1", idx, bus_if.E_lect);
         end
      end
   endtask

   task automatic run_read(input logic [7:0] mask, input int busy_idx, input int rst_idx);
      bit ab;
      bus_cycles = 0;
      start_read(mask);
      for (int i = 0; i < 10; i++) begin
         bus_cycle(i, mask, busy_idx, rst_idx, ab);
         if (ab) return;
      end
      // In DONE: old values still visible, strobe not yet raised.
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (got[j] !== pub_model[j] || Dato_Valido !== 1'b0) begin
            errors++;
            $display("FAIL pre_publish[%0d]: got %h valido=%b want %h 0", j, got[j], Dato_Valido,
                     pub_model[j]);
         end
      end
      @(negedge clk);
      for (int j = 0; j < 9; j++) pub_model[j] = exp_pub_q.pop_front();
      checks++;
      if (Dato_Valido !== 1'b1 || Term_Lect !== 1'b1 || bus_if.Rd_Wr !== 1'b0) begin
         errors++;
         $display("FAIL done_flags: Valido=%b Term_Lect=%b Rd_Wr=%b want 1 1 0", Dato_Valido,
                  Term_Lect, bus_if.Rd_Wr);
      end
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (got[j] !== pub_model[j]) begin
            errors++;
            $display("FAIL publish[%0d]: got %h want %h", j, got[j], pub_model[j]);
         end
      end
      @(negedge clk);
      checks++;
      if (Dato_Valido !== 1'b0 || bus_if.E_lect !== 1'b0 || Term_Lect !== 1'b1) begin
         errors++;
         $display("FAIL post_done: Valido=%b E_lect=%b Term_Lect=%b want 0 0 1", Dato_Valido,
                  bus_if.E_lect, Term_Lect);
      end
      checks++;
      if (bus_cycles != 10) begin
         errors++;
         $display("FAIL bus_cycle_count: got %0d want 10", bus_cycles);
      end
   endtask

   task automatic test_full_read();
      logic [7:0] want [9];
      want = '{8'h74, 8'h77, 8'h76, 8'h71, 8'h70, 8'h73, 8'h14, 8'h17, 8'h16};
      run_read(8'h55, -1, -1);
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (got[j] !== want[j]) begin
            errors++;
            $display("FAIL full_read_value[%0d]: got %h want %h", j, got[j], want[j]);
         end
      end
   endtask

   task automatic test_atomicity();
      run_read(8'hAA, -1, -1);
   endtask

   task automatic test_busy_ignore();
      run_read(8'h3C, 2, -1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus_if.E_lect !== 1'b0 || Term_Lect !== 1'b1) begin
            errors++;
            $display("FAIL busy_no_restart[%0d]: E_lect=%b Term_Lect=%b want 0 1", i,
                     bus_if.E_lect, Term_Lect);
         end
      end
   endtask

   task automatic test_reset_midop();
      run_read(8'h5A, -1, 3);
      run_read(8'h55, -1, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      addr_tab = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
      for (int j = 0; j < 9; j++) pub_model[j] = 8'h00;
      reset = 1'b1;
      Lectura = 1'b0;
      bus_if.DIR = 1'b0;
      bus_if.DAT = 1'b0;
      bus_if.cambio_estado = 1'b0;
      bus_if.Dato_In = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_full_read();
      test_atomicity();
      test_busy_ignore();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
